uart_tx_cts: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_fifo.sv | 80 ++++++++
 rtl/uart_tx_cts.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_cts.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the ZXUNO UART path: data width, transmitter state
// encoding and the clocks-per-bit helper. The transmitter imports it, and a
// future receiver can import it as well.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_W = 8;

    // PARITY is always part of the encoding. It is only reachable when
    // UART_TX_PARITY_EN is defined.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        BIT    = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } tx_state_t;

    // Clocks per bit cell. The result must fit in 16 bits and be >= 4.
    function automatic int calc_period(input int clk_hz, input int bps);
        return clk_hz / bps;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// -----------------------------------------------------------------------------
// uart_fifo
// Synchronous byte FIFO with a first-word-fall-through head. rdata always shows
// the oldest entry, and pop consumes it. A write is accepted only when the
// *current* count is below depth, so a pop in the same cycle does not make
// room. full and empty are registered from the next count.
//
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (pointers, count, flags)
//   wdata  in   W   data to store
//   write  in   write request (ignored while full)
//   pop    in   consume head (ignored while empty)
//   rdata  out  W   head entry
//   full   out  count == depth
//   empty  out  count == 0
//   count  out  AW+1 number of stored entries
// -----------------------------------------------------------------------------
module uart_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  wdata,
    input  logic          write,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count_next;
    logic          wr_ok;
    logic          rd_ok;

    assign wr_ok = write && !full;
    assign rd_ok = pop && !empty;

    always_comb begin
        count_next = count;
        if (wr_ok && !rd_ok)
            count_next = count + 1'b1;
        else if (!wr_ok && rd_ok)
            count_next = count - 1'b1;
    end

    // Storage holds data only, so it is not reset.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (wr_ok)
                wptr <= wptr + 1'b1;
            if (rd_ok)
                rptr <= rptr + 1'b1;
            count <= count_next;
            full  <= (count_next == (AW+1)'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    assign rdata = mem[rptr];

endmodule

// File: rtl/uart_tx_cts.sv
// -----------------------------------------------------------------------------
// uart_tx_cts
// Buffered RS232 transmitter, 8N1, LSB first, with peer flow control. Bytes
// are queued in a 16-deep FIFO. A new frame starts only from IDLE while the
// synchronised cts is low. Raising cts mid-frame lets the current frame finish.
//
// Optional build macro: UART_TX_PARITY_EN adds an even-parity bit cell between
// the data bits and the stop bit, which gives an 8E1 frame. Ports are the same
// in both builds.
//
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   txdata   in   8  byte to queue
//   txwrite  in   one-cycle write strobe
//   txfull   out  FIFO full (writes dropped)
//   txempty  out  FIFO empty
//   txbusy   out  FIFO non-empty or frame in progress
//   cts      in   asynchronous peer hold request (1 = hold)
//   tx       out  serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_cts
    import uart_pkg::*;
#(
    parameter int CLK     = 28000000,
    parameter int BPS     = 115200,
    parameter int PERIOD  = calc_period(CLK, BPS),
    parameter int FIFO_AW = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] txdata,
    input  logic       txwrite,
    output logic       txfull,
    output logic       txempty,
    output logic       txbusy,
    input  logic       cts,
    output logic       tx
);

    localparam logic [15:0] PERIOD_M1 = 16'(PERIOD - 1);

    tx_state_t              state;
    logic [15:0]            cnt;
    logic [2:0]             bitcnt;
    logic [UART_DATA_W-1:0] shift;
    logic [UART_DATA_W-1:0] head;
    logic [FIFO_AW:0]       fifo_count;
    logic                   cts_meta;
    logic                   cts_s;
    logic                   pop;
    logic                   line_level;
`ifdef UART_TX_PARITY_EN
    logic                   parity;
`endif

    // Two-flop synchroniser for the asynchronous peer hold line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cts_meta <= 1'b0;
            cts_s    <= 1'b0;
        end else begin
            cts_meta <= cts;
            cts_s    <= cts_meta;
        end
    end

    assign pop = (state == IDLE) && !txempty && !cts_s;

    uart_fifo #(
        .W  (UART_DATA_W),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wdata (txdata),
        .write (txwrite),
        .pop   (pop),
        .rdata (head),
        .full  (txfull),
        .empty (txempty),
        .count (fifo_count)
    );

    // Line level for the current state. tx registers it, so the line lags
    // the state by one clock. Every cell still lasts exactly PERIOD clocks,
    // and a write at edge N shows its start bit from edge N+2.
    always_comb begin
        line_level = 1'b1;
        case (state)
            START:   line_level = 1'b0;
            BIT:     line_level = shift[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  line_level = parity;
`endif
            default: line_level = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            bitcnt <= '0;
            shift  <= '0;
            tx     <= 1'b1;
            txbusy <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity <= 1'b0;
`endif
        end else begin
            tx     <= line_level;
            txbusy <= (state != IDLE) || (fifo_count != '0);
            case (state)
                IDLE: begin
                    // cts is only looked at here, so a frame that has started always finishes.
                    if (pop) begin
                        shift <= head;
                        cnt   <= PERIOD_M1;
                        state <= START;
`ifdef UART_TX_PARITY_EN
                        parity <= ^head;
`endif
                    end
                end
                START: begin
                    if (cnt == '0) begin
                        cnt    <= PERIOD_M1;
                        bitcnt <= 3'd7;
                        state  <= BIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                BIT: begin
                    if (cnt == '0) begin
                        shift <= shift >> 1;
                        cnt   <= PERIOD_M1;
                        if (bitcnt == '0) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bitcnt <= bitcnt - 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (cnt == '0) begin
                        cnt   <= PERIOD_M1;
                        state <= STOP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (cnt == '0)
                        state <= IDLE;
                    else
                        cnt <= cnt - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_cts.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_cts
// Bench for uart_tx_cts with PERIOD = 16 (CLK=1600, BPS=100). Every accepted
// byte goes into a scoreboard queue when it is written. A line monitor captures
// each frame at the negative clock edge, checks the cell shapes, and compares
// the decoded byte against the head of the queue.
// -----------------------------------------------------------------------------
module tb_uart_tx_cts;

    localparam int P = 16;
`ifdef UART_TX_PARITY_EN
    localparam int NCELL = 11;
`else
    localparam int NCELL = 10;
`endif
    localparam int FRAME = NCELL * P;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] txdata = '0;
    logic       txwrite = 1'b0;
    logic       txfull;
    logic       txempty;
    logic       txbusy;
    logic       cts = 1'b0;
    logic       tx;

    uart_tx_cts #(
        .CLK     (1600),
        .BPS     (100),
        .FIFO_AW (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .txdata  (txdata),
        .txwrite (txwrite),
        .txfull  (txfull),
        .txempty (txempty),
        .txbusy  (txbusy),
        .cts     (cts),
        .tx      (tx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int frames_rx = 0;
    logic [7:0] sb [$];

    // Set by the test while frames must follow each other with one idle clock.
    logic b2b = 1'b0;
    logic last_par = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Line monitor.
    initial begin : monitor
        logic [FRAME-1:0] smp;
        logic [7:0] rx_byte;
        logic [7:0] exp_byte;
        logic aborted;
        int start_cyc;
        int prev_start;
        logic have_prev;
        int bad;
        have_prev = 1'b0;
        prev_start = 0;
        forever begin
            @(negedge clk);
            if (!b2b)
                have_prev = 1'b0;
            if (rst_n && tx === 1'b0) begin
                start_cyc = cyc;
                aborted = 1'b0;
                smp[0] = tx;
                for (int i = 1; i < FRAME; i++) begin
                    @(negedge clk);
                    smp[i] = tx;
                    if (!rst_n)
                        aborted = 1'b1;
                end
                if (!aborted) begin
                    bad = 0;
                    for (int c = 0; c < NCELL; c++)
                        for (int j = 1; j < P; j++)
                            if (smp[c*P+j] !== smp[c*P]) bad++;
                    check("cell_shape", bad, 0);
                    check("start_bit", 32'(smp[0]), 0);
                    check("stop_bit", 32'(smp[(NCELL-1)*P]), 1);
                    for (int b = 0; b < 8; b++)
                        rx_byte[b] = smp[(b+1)*P];
`ifdef UART_TX_PARITY_EN
                    last_par = smp[9*P];
                    check("parity_bit", 32'(last_par), 32'(^rx_byte));
`endif
                    if (sb.size() == 0) begin
                        check("unexpected_frame", 32'(rx_byte), 32'hFFFF_FFFF);
                    end else begin
                        exp_byte = sb.pop_front();
                        check("rx_byte", 32'(rx_byte), 32'(exp_byte));
                    end
                    if (b2b) begin
                        if (have_prev)
                            check("frame_gap", start_cyc - prev_start, FRAME + 1);
                        prev_start = start_cyc;
                        have_prev = 1'b1;
                    end
                    frames_rx++;
                end
            end
        end
    end

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames_rx < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("frame_count", frames_rx, target);
    endtask

    // Counts negedges until tx goes low. Returns -1 if the budget expires.
    task automatic wait_tx_low(input int budget, output int k);
        k = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (tx === 1'b0) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic write_byte(input logic [7:0] d);
        txdata  = d;
        txwrite = 1'b1;
        sb.push_back(d);
        @(negedge clk);
        txwrite = 1'b0;
    endtask

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish, frames %0d", frames_rx);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int k;
        int lows;
        int base;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 1);
        check("rst_txfull", 32'(txfull), 0);
        check("rst_txempty", 32'(txempty), 1);
        check("rst_txbusy", 32'(txbusy), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single byte 0xA5, latency and txbusy timing
        txdata = 8'hA5; txwrite = 1'b1; sb.push_back(8'hA5);
        @(negedge clk);                       // after write edge N
        txwrite = 1'b0;
        check("single_notempty", 32'(txempty), 0);
        @(negedge clk);                       // after N+1
        check("lat_pre_start", 32'(tx), 1);
        @(negedge clk);                       // after N+2
        check("lat_start", 32'(tx), 0);
        check("single_busy", 32'(txbusy), 1);
        repeat (FRAME - 1) @(negedge clk);    // last stop sample
        check("busy_last_stop", 32'(txbusy), 1);
        @(negedge clk);
        check("busy_fall", 32'(txbusy), 0);
        check("single_empty", 32'(txempty), 1);
        wait_frames(1, 50);

        // Burst of 16 with cts held, then a dropped 17th write
        cts = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            txdata = 8'(i); txwrite = 1'b1; sb.push_back(8'(i));
            @(negedge clk);
        end
        txwrite = 1'b0;
        check("burst_full", 32'(txfull), 1);
        txdata = 8'hFF; txwrite = 1'b1;       // must be dropped
        @(negedge clk);
        txwrite = 1'b0;
        check("burst_full_hold", 32'(txfull), 1);
        check("burst_count", 32'(dut.u_fifo.count), 16);
        base = frames_rx;
        b2b = 1'b1;
        cts = 1'b0;
        wait_frames(base + 16, 16 * (FRAME + 10));
        b2b = 1'b0;
        check("burst_empty", 32'(txempty), 1);
        repeat (5) @(negedge clk);

        // Flow control: cts held from reset
        cts = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        write_byte(8'h55);
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("cts_hold_line", lows, 0);
        check("cts_hold_queued", 32'(txempty), 0);
        base = frames_rx;
        cts = 1'b0;
        wait_tx_low(20, k);
        check("cts_release_lat", 32'(k >= 3 && k <= 4), 1);
        wait_frames(base + 1, FRAME + 20);

        // cts raised mid-frame: 0x11 completes, 0x22 held
        repeat (3) @(negedge clk);
        base = frames_rx;
        write_byte(8'h11);
        write_byte(8'h22);
        wait_tx_low(20, k);
        check("mid_start_seen", 32'(k > 0), 1);
        repeat (50) @(negedge clk);
        cts = 1'b1;
        wait_frames(base + 1, FRAME + 20);
        repeat (300) @(negedge clk);
        check("mid_held_frames", frames_rx, base + 1);
        check("mid_held_queued", 32'(txempty), 0);
        check("mid_held_line", 32'(tx), 1);
        cts = 1'b0;
        wait_frames(base + 2, FRAME + 30);

        // Simultaneous write and pop at count = 1
        repeat (3) @(negedge clk);
        base = frames_rx;
        txdata = 8'h31; txwrite = 1'b1; sb.push_back(8'h31);
        @(negedge clk);                       // after edge N: count 1
        check("simul_count_pre", 32'(dut.u_fifo.count), 1);
        txdata = 8'h32; sb.push_back(8'h32);
        @(negedge clk);                       // after edge N+1: write and pop
        txwrite = 1'b0;
        check("simul_count", 32'(dut.u_fifo.count), 1);
        wait_frames(base + 2, 2 * FRAME + 30);

        // Reset in the middle of bit 3 of 0x0F
        repeat (3) @(negedge clk);
        base = frames_rx;
        write_byte(8'h0F);
        wait_tx_low(20, k);
        repeat (4 * P + 8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstmid_tx", 32'(tx), 1);
        check("rstmid_empty", 32'(txempty), 1);
        check("rstmid_busy", 32'(txbusy), 0);
        check("rstmid_full", 32'(txfull), 0);
        sb.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("rstmid_quiet", lows, 0);
        check("rstmid_frames", frames_rx, base);

`ifdef UART_TX_PARITY_EN
        // Parity build: 0x07 -> 1, 0x03 -> 0
        base = frames_rx;
        write_byte(8'h07);
        wait_frames(base + 1, FRAME + 30);
        check("par_07", 32'(last_par), 1);
        repeat (3) @(negedge clk);
        write_byte(8'h03);
        wait_frames(base + 2, FRAME + 30);
        check("par_03", 32'(last_par), 0);
`endif

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
